// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS constants, AER transmitter state encoding and word-packing helpers.
package dvs_ravens_pkg;

    localparam int unsigned DVS_X_ADDR_BITS = 9;
    localparam int unsigned DVS_Y_ADDR_BITS = 9;
    localparam int unsigned AER_BUS_BITS    = 10;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_Y_SETUP = 3'd1,
        TX_Y_REQ   = 3'd2,
        TX_Y_REL   = 3'd3,
        TX_X_SETUP = 3'd4,
        TX_X_REQ   = 3'd5,
        TX_X_REL   = 3'd6
    } aer_tx_state_t;

    typedef struct packed {
        logic [DVS_X_ADDR_BITS-1:0] x;
        logic [DVS_Y_ADDR_BITS-1:0] y;
        logic                       pol;
    } dvs_event_t;

    function automatic logic [AER_BUS_BITS-1:0] aer_y_word(input logic [DVS_Y_ADDR_BITS-1:0] y);
        return AER_BUS_BITS'(y);
    endfunction

    // X address sits above the polarity bit
    function automatic logic [AER_BUS_BITS-1:0] aer_x_word(input logic [DVS_X_ADDR_BITS-1:0] x,
                                                           input logic                       pol);
        return AER_BUS_BITS'({x, pol});
    endfunction

endpackage

// File: rtl/dvs_sync_ff.sv
// Parameterised multi-flop synchroniser for asynchronous inputs (e.g. AER ack/req).
module dvs_sync_ff #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("dvs_sync_ff: STAGES must be >= 2");
    end

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dvs_aer_transmitter.sv
// AER transmitter: sends each (x, y, polarity) event as a Y word then an X word over four-phase req/ack.
// Optional: define DVS_AER_TX_ROW_SKIP_EN to omit the Y word when the row repeats the last completed one.
module dvs_aer_transmitter
    import dvs_ravens_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES       = 2,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DVS_X_ADDR_BITS-1:0] in_x,
    input  logic [DVS_Y_ADDR_BITS-1:0] in_y,
    input  logic                       in_polarity,
    output logic [AER_BUS_BITS-1:0]    aer,
    output logic                       xsel,
    output logic                       req,
    input  logic                       ack,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int unsigned TO_W  = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES + 1) : 1;

    if (DVS_X_ADDR_BITS > AER_BUS_BITS - 1) begin : g_bad_x
        $error("dvs_aer_transmitter: DVS_X_ADDR_BITS must be <= 9");
    end
    if (DVS_Y_ADDR_BITS > AER_BUS_BITS) begin : g_bad_y
        $error("dvs_aer_transmitter: DVS_Y_ADDR_BITS must be <= 10");
    end
    if (SETUP_CYCLES < 1) begin : g_bad_setup
        $error("dvs_aer_transmitter: SETUP_CYCLES must be >= 1");
    end

    aer_tx_state_t           state_q, state_d;
    dvs_event_t              ev_q, ev_d;
    logic [SET_W-1:0]        set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d, to_inc;
    logic [AER_BUS_BITS-1:0] aer_q, aer_d;
    logic                    xsel_q, xsel_d;
    logic                    req_q, busy_q, in_ready_q, timeout_err_q;
    logic                    ack_s, skip_c, timeout_c, in_handshake_c;

    dvs_sync_ff #(
        .STAGES(SYNC_STAGES),
        .WIDTH (1)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (ack),
        .q_o  (ack_s)
    );

`ifdef DVS_AER_TX_ROW_SKIP_EN
    logic [DVS_Y_ADDR_BITS-1:0] last_y_q;
    logic                       row_valid_q;
    logic                       row_done_c;

    assign row_done_c = (state_q == TX_X_REL) && !ack_s;
    assign skip_c     = row_valid_q && (in_y == last_y_q);

    // Row is remembered only once an X word has fully completed its handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_y_q    <= '0;
            row_valid_q <= 1'b0;
        end else if (timeout_c) begin
            row_valid_q <= 1'b0;
        end else if (row_done_c) begin
            last_y_q    <= ev_q.y;
            row_valid_q <= 1'b1;
        end
    end
`else
    assign skip_c = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        ev_d           = ev_q;
        aer_d          = aer_q;
        xsel_d         = xsel_q;
        timeout_c      = 1'b0;
        in_handshake_c = 1'b0;
        to_inc         = to_cnt_q + TO_W'(1);

        unique case (state_q)
            TX_IDLE: begin
                if (in_valid && in_ready_q) begin
                    ev_d    = '{x: in_x, y: in_y, pol: in_polarity};
                    state_d = skip_c ? TX_X_SETUP : TX_Y_SETUP;
                end
            end
            TX_Y_SETUP: if (set_cnt_q == SET_W'(SETUP_CYCLES - 1)) state_d = TX_Y_REQ;
            TX_Y_REQ: begin
                in_handshake_c = 1'b1;
                if (ack_s) state_d = TX_Y_REL;
            end
            TX_Y_REL: begin
                in_handshake_c = 1'b1;
                if (!ack_s) state_d = TX_X_SETUP;
            end
            TX_X_SETUP: if (set_cnt_q == SET_W'(SETUP_CYCLES - 1)) state_d = TX_X_REQ;
            TX_X_REQ: begin
                in_handshake_c = 1'b1;
                if (ack_s) state_d = TX_X_REL;
            end
            TX_X_REL: begin
                in_handshake_c = 1'b1;
                if (!ack_s) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase

        // A stalled responder abandons the event; a handshake edge in the same cycle wins
        if ((ACK_TIMEOUT_CYCLES != 0) && in_handshake_c && (state_d == state_q) &&
            (to_inc == TO_W'(ACK_TIMEOUT_CYCLES))) begin
            timeout_c = 1'b1;
            state_d   = TX_IDLE;
        end

        set_cnt_d = (state_d != state_q) ? '0 :
                    ((state_q == TX_Y_SETUP) || (state_q == TX_X_SETUP)) ? set_cnt_q + SET_W'(1) : set_cnt_q;
        to_cnt_d  = (state_d != state_q) ? '0 : (in_handshake_c ? to_inc : to_cnt_q);

        if (state_d != state_q) begin
            if (state_d == TX_Y_SETUP) begin
                aer_d  = aer_y_word(ev_d.y);
                xsel_d = 1'b0;
            end else if (state_d == TX_X_SETUP) begin
                aer_d  = aer_x_word(ev_d.x, ev_d.pol);
                xsel_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= TX_IDLE;
            ev_q          <= '0;
            set_cnt_q     <= '0;
            to_cnt_q      <= '0;
            aer_q         <= '0;
            xsel_q        <= 1'b0;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ev_q          <= ev_d;
            set_cnt_q     <= set_cnt_d;
            to_cnt_q      <= to_cnt_d;
            aer_q         <= aer_d;
            xsel_q        <= xsel_d;
            req_q         <= (state_d == TX_Y_REQ) || (state_d == TX_X_REQ);
            busy_q        <= (state_d != TX_IDLE);
            in_ready_q    <= (state_d == TX_IDLE);
            timeout_err_q <= timeout_c;
        end
    end

    assign in_ready    = in_ready_q;
    assign aer         = aer_q;
    assign xsel        = xsel_q;
    assign req         = req_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// Self-checking bench for dvs_aer_transmitter: AER responder model plus word scoreboard.
module tb_dvs_aer_transmitter;
    import dvs_ravens_pkg::*;

    localparam int unsigned SETUP = 2;
    localparam int unsigned TO    = 16;
    localparam int unsigned SYNC  = 2;
`ifdef DVS_AER_TX_ROW_SKIP_EN
    localparam bit ROW_SKIP = 1'b1;
`else
    localparam bit ROW_SKIP = 1'b0;
`endif

    logic                       clk         = 1'b0;
    logic                       rst_n       = 1'b0;
    logic                       in_valid    = 1'b0;
    logic                       in_ready;
    logic [DVS_X_ADDR_BITS-1:0] in_x        = '0;
    logic [DVS_Y_ADDR_BITS-1:0] in_y        = '0;
    logic                       in_polarity = 1'b0;
    logic [AER_BUS_BITS-1:0]    aer;
    logic                       xsel;
    logic                       req;
    logic                       ack         = 1'b0;
    logic                       busy;
    logic                       timeout_err;

    int checks = 0;
    int passed = 0;

    logic [10:0] exp_q[$];
    logic [10:0] log_q[$];
    bit                         row_valid_m = 1'b0;
    logic [DVS_Y_ADDR_BITS-1:0] last_y_m    = '0;

    bit resp_en   = 1'b0;
    bit resp_rand = 1'b0;
    int up_dly    = 3;
    int dn_dly    = 3;
    int dly_cnt   = 0;
    bit mon_en    = 1'b0;

    dvs_aer_transmitter #(
        .SETUP_CYCLES      (SETUP),
        .ACK_TIMEOUT_CYCLES(TO),
        .SYNC_STAGES       (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_polarity(in_polarity),
        .aer        (aer),
        .xsel       (xsel),
        .req        (req),
        .ack        (ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Four-phase responder: raises ack up_dly cycles after req, drops it dn_dly cycles after req falls
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!resp_en) begin
                ack     = 1'b0;
                dly_cnt = 0;
            end else if (req !== ack) begin
                if (dly_cnt >= (ack ? dn_dly : up_dly)) begin
                    ack     = ~ack;
                    dly_cnt = 0;
                    if (resp_rand) begin
                        up_dly = $urandom_range(10, 0);
                        dn_dly = $urandom_range(10, 0);
                    end
                end else begin
                    dly_cnt++;
                end
            end else begin
                dly_cnt = 0;
            end
        end
    end

    // Word decoder, scoreboard and bus-stability monitor
    initial begin
        logic [10:0] cur, prev_word, e;
        logic        prev_req;
        int          stable;
        prev_word = '0;
        prev_req  = 1'b0;
        stable    = 0;
        forever begin
            @(negedge clk);
            cur = {xsel, aer};
            if (req && !prev_req) begin
                log_q.push_back(cur);
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard: unexpected word %h with nothing pending", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) $display("FAIL scoreboard: word got %h expected %h", cur, e);
                    else passed++;
                end
            end
            if (mon_en) begin
                checks++;
                if ((cur !== prev_word) && (req || prev_req || ack))
                    $display("FAIL bus_stable: word %h -> %h while req=%b prev_req=%b ack=%b", prev_word, cur, req, prev_req, ack);
                else passed++;
                if (cur !== prev_word) stable = 0;
                if (req && !prev_req) begin
                    checks++;
                    if (stable < int'(SETUP)) $display("FAIL setup_time: got %0d cycles expected >= %0d", stable, SETUP);
                    else passed++;
                end
                checks++;
                if (in_ready !== ~busy) $display("FAIL ready_only_idle: in_ready=%b busy=%b", in_ready, busy);
                else passed++;
                stable++;
            end
            prev_req  = req;
            prev_word = cur;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_expected(input logic [DVS_X_ADDR_BITS-1:0] x,
                                          input logic [DVS_Y_ADDR_BITS-1:0] y, input logic p);
        if (!(ROW_SKIP && row_valid_m && (y == last_y_m))) exp_q.push_back({1'b0, 10'(y)});
        exp_q.push_back({1'b1, 10'({x, p})});
        row_valid_m = 1'b1;
        last_y_m    = y;
    endfunction

    task automatic send_event(input logic [DVS_X_ADDR_BITS-1:0] x, input logic [DVS_Y_ADDR_BITS-1:0] y,
                              input logic p, input bit keep);
        bit acc;
        acc         = 1'b0;
        in_valid    = 1'b1;
        in_x        = x;
        in_y        = y;
        in_polarity = p;
        for (int i = 0; i < 400 && !acc; i++) begin
            if (in_ready) begin
                push_expected(x, y, p);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        if (!keep) in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL send_event: x=%0d y=%0d not accepted within 400 cycles", x, y);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (!busy && exp_q.size() == 0) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++;
            $display("FAIL wait_idle: busy=%b pending=%0d after %0d cycles", busy, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0)    $display("FAIL rst_in_ready: got %b expected 0", in_ready); else passed++;
        checks++; if (aer !== '0)           $display("FAIL rst_aer: got %h expected 0", aer); else passed++;
        checks++; if (xsel !== 1'b0)        $display("FAIL rst_xsel: got %b expected 0", xsel); else passed++;
        checks++; if (req !== 1'b0)         $display("FAIL rst_req: got %b expected 0", req); else passed++;
        checks++; if (busy !== 1'b0)        $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (busy !== 1'b0)     $display("FAIL idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_basic();
        bit ok;
        resp_en = 1'b1; resp_rand = 1'b0; up_dly = 3; dn_dly = 3;
        log_q.delete();
        send_event(9'd37, 9'd12, 1'b1, 1'b0);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) $display("FAIL basic_busy_release: got %b expected 1", ok); else passed++;
        checks++; if (log_q.size() != 2) $display("FAIL basic_word_count: got %0d expected 2", log_q.size()); else passed++;
        if (log_q.size() == 2) begin
            checks++; if (log_q[0] !== 11'h00C) $display("FAIL basic_y_word: got %h expected 00c", log_q[0]); else passed++;
            checks++; if (log_q[1] !== 11'h44B) $display("FAIL basic_x_word: got %h expected 44b", log_q[1]); else passed++;
        end
    endtask

    task automatic test_row_skip();
        bit          ok;
        logic [10:0] exp_w[$];
        logic [10:0] got;
        log_q.delete();
        send_event(9'd5, 9'd7, 1'b0, 1'b0);
        send_event(9'd9, 9'd7, 1'b0, 1'b0);
        send_event(9'd2, 9'd8, 1'b0, 1'b0);
        wait_idle(300, ok);
        if (ROW_SKIP) exp_w = '{11'h007, 11'h40A, 11'h412, 11'h008, 11'h404};
        else          exp_w = '{11'h007, 11'h40A, 11'h007, 11'h412, 11'h008, 11'h404};
        checks++;
        if (log_q.size() != exp_w.size()) $display("FAIL row_word_count: got %0d expected %0d", log_q.size(), exp_w.size());
        else passed++;
        for (int i = 0; i < exp_w.size(); i++) begin
            got = (i < log_q.size()) ? log_q[i] : 11'hxxx;
            checks++;
            if (got !== exp_w[i]) $display("FAIL row_word_%0d: got %h expected %h", i, got, exp_w[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        mon_en = 1'b1;
        log_q.delete();
        for (int i = 0; i < 4; i++)
            send_event(DVS_X_ADDR_BITS'(100 + i), DVS_Y_ADDR_BITS'(200 + i), 1'(i), (i != 3));
        wait_idle(300, ok);
        mon_en = 1'b0;
        checks++; if (log_q.size() != 8) $display("FAIL b2b_word_count: got %0d expected 8", log_q.size()); else passed++;
    endtask

    task automatic test_random();
        bit ok;
        mon_en = 1'b1; resp_rand = 1'b1;
        for (int i = 0; i < 500; i++)
            send_event(DVS_X_ADDR_BITS'($urandom()), DVS_Y_ADDR_BITS'($urandom()), 1'($urandom()), 1'b0);
        wait_idle(300, ok);
        mon_en = 1'b0; resp_rand = 1'b0; up_dly = 3; dn_dly = 3;
        checks++; if (ok !== 1'b1) $display("FAIL random_drain: got %b expected 1", ok); else passed++;
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        resp_en = 1'b0;
        send_event(9'd7, 9'd300, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !req; i++) @(negedge clk);
        hi = 0;
        while (req && hi < 64) begin
            hi++;
            @(negedge clk);
        end
        checks++; if (hi != int'(TO))        $display("FAIL to_req_width: got %0d expected %0d", hi, TO); else passed++;
        checks++; if (timeout_err !== 1'b1) $display("FAIL to_pulse: got %b expected 1", timeout_err); else passed++;
        checks++; if (in_ready !== 1'b1)    $display("FAIL to_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (exp_q.size() != 1)    $display("FAIL to_pending: got %0d expected 1", exp_q.size()); else passed++;
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0) $display("FAIL to_single_pulse: got %b expected 0", timeout_err); else passed++;
        exp_q.delete();
        row_valid_m = 1'b0;
        resp_en = 1'b1;
        send_event(9'd11, 9'd301, 1'b0, 1'b0);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) $display("FAIL to_recover: got %b expected 1", ok); else passed++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        resp_en = 1'b1; up_dly = 8; dn_dly = 2;
        send_event(9'd200, 9'd50, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (req && xsel) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (seen !== 1'b1) $display("FAIL mid_reach_x_req: got %b expected 1", seen); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req !== 1'b0)  $display("FAIL mid_req_async: got %b expected 0", req); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy_async: got %b expected 0", busy); else passed++;
        @(negedge clk);
        exp_q.delete();
        row_valid_m = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)    $display("FAIL mid_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (aer !== '0)           $display("FAIL mid_aer: got %h expected 0", aer); else passed++;
        checks++; if (xsel !== 1'b0)        $display("FAIL mid_xsel: got %b expected 0", xsel); else passed++;
        checks++; if (req !== 1'b0)         $display("FAIL mid_req: got %b expected 0", req); else passed++;
        checks++; if (busy !== 1'b0)        $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL mid_timeout_err: got %b expected 0", timeout_err); else passed++;
        up_dly = 3;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_row_skip();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
